// File: rtl/suma_if.sv
// rtl/suma_if.sv - operand/result bundle for the binary32 adder
interface suma_if;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] out;
  logic        out_valid;

  modport master (output in_valid, output A, output B, input out, input out_valid);
  modport slave  (input in_valid, input A, input B, output out, output out_valid);
endinterface

// File: rtl/suma.sv
// rtl/suma.sv - binary32 adder, round-to-nearest-even, flush-to-zero,
// combinational datapath into a single result register
module suma (
  input  logic    clk,
  input  logic    rst_n,
  suma_if.slave   bus_io
);
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa = bus_io.A[31];
  assign sb = bus_io.B[31];
  assign ea = bus_io.A[30:23];
  assign eb = bus_io.B[30:23];
  assign fa = bus_io.A[22:0];
  assign fb = bus_io.B[22:0];

  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  // Larger magnitude goes first; comparing exponent:fraction as one integer suffices.
  logic        swap;
  logic        sl;
  logic [7:0]  el, es, exp_diff;
  logic [23:0] ml, ms;

  assign swap     = (bus_io.B[30:0] > bus_io.A[30:0]);
  assign sl       = swap ? sb : sa;
  assign el       = swap ? eb : ea;
  assign es       = swap ? ea : eb;
  assign ml       = swap ? {1'b1, fb} : {1'b1, fa};
  assign ms       = swap ? {1'b1, fa} : {1'b1, fb};
  assign exp_diff = el - es;

  // 27-bit working format: 24-bit significand, guard, round, sticky.
  logic [49:0] ext;
  logic [26:0] big_x, small_x;
  logic [27:0] add_res;
  logic [26:0] sub_res;

  assign ext     = {ms, 26'd0} >> exp_diff;
  assign small_x = (exp_diff >= 8'd26) ? 27'd1 : {ext[49:24], |ext[23:0]};
  assign big_x   = {ml, 3'b000};
  assign add_res = {1'b0, big_x} + {1'b0, small_x};
  assign sub_res = big_x - small_x;

  logic [4:0] lzc;
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i <= 26; i++) begin
      if (sub_res[i]) lzc = 5'(26 - i);
    end
  end

  logic [26:0] norm;
  logic [9:0]  exp_n;
  logic        uflow_n;
  logic        cancel;
  logic        res_sign;

  always_comb begin
    norm     = 27'd0;
    exp_n    = 10'd0;
    uflow_n  = 1'b0;
    cancel   = 1'b0;
    res_sign = sl;
    if (sa == sb) begin
      if (add_res[27]) begin
        norm  = {add_res[27:2], add_res[1] | add_res[0]};
        exp_n = {2'b00, el} + 10'd1;
      end else begin
        norm  = add_res[26:0];
        exp_n = {2'b00, el};
      end
    end else if (sub_res == 27'd0) begin
      cancel   = 1'b1;
      res_sign = 1'b0;
    end else begin
      norm    = sub_res << lzc;
      uflow_n = ({3'b000, lzc} >= el);
      exp_n   = {2'b00, el} - {5'd0, lzc};
    end
  end

  logic        round_up;
  logic [24:0] sig_r;
  logic [9:0]  exp_f;
  logic [22:0] frac_f;

  assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign sig_r    = {1'b0, norm[26:3]} + {24'd0, round_up};
  assign exp_f    = exp_n + {9'd0, sig_r[24]};
  assign frac_f   = sig_r[24] ? sig_r[23:1] : sig_r[22:0];

  logic [31:0] sum_d;
  always_comb begin
    sum_d = 32'h0000_0000;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      sum_d = 32'h7FC0_0000;
    end else if (a_inf) begin
      sum_d = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      sum_d = {sb, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      sum_d = {sa & sb, 31'd0};
    end else if (a_zero) begin
      sum_d = bus_io.B;
    end else if (b_zero) begin
      sum_d = bus_io.A;
    end else if (cancel || uflow_n) begin
      sum_d = {res_sign & ~cancel, 31'd0};
    end else if (exp_f >= 10'd255) begin
      sum_d = {res_sign, 8'hFF, 23'd0};
    end else begin
      sum_d = {res_sign, exp_f[7:0], frac_f};
    end
  end

  logic [31:0] out_q;
  logic        out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 32'h0000_0000;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus_io.in_valid;
      if (bus_io.in_valid) out_q <= sum_d;
    end
  end

  assign bus_io.out       = out_q;
  assign bus_io.out_valid = out_valid_q;
endmodule

// File: tb/tb_suma.sv
// tb/tb_suma.sv - directed-vector bench for the binary32 adder
module tb_suma;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  suma_if bus_if ();

  suma dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Present a pair at the falling edge, sample just after the next rising edge.
  task automatic add_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.A        = a;
    bus_if.B        = b;
    @(posedge clk);
    #1;
    check(tag, bus_if.out, exp);
    check({tag, "_v"}, {31'd0, bus_if.out_valid}, 32'd1);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.A        = 32'h3F80_0000;
    bus_if.B        = 32'h3F80_0000;
    #2;
    check("rst_out", bus_if.out, 32'h0);
    check("rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_out", bus_if.out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.in_valid = 1'b0;

    vecs.push_back('{"tie_even",  32'h3EEB851E, 32'h3F4A3D70, 32'h3FA00000});
    vecs.push_back('{"dbl_a",     32'h3EEB851E, 32'h3EEB851E, 32'h3F6B851E});
    vecs.push_back('{"dbl_b",     32'h3F4A3D70, 32'h3F4A3D70, 32'h3FCA3D70});
    vecs.push_back('{"dbl_q",     32'h3E800000, 32'h3E800000, 32'h3F000000});
    vecs.push_back('{"pow_ab",    32'h3E800000, 32'h3F000000, 32'h3F400000});
    vecs.push_back('{"pow_ba",    32'h3F000000, 32'h3E800000, 32'h3F400000});
    vecs.push_back('{"half_half", 32'h3F000000, 32'h3F000000, 32'h3F800000});
    vecs.push_back('{"tie_swap",  32'h3F4A3D70, 32'h3EEB851E, 32'h3FA00000});
    vecs.push_back('{"cancel",    32'h3F800000, 32'hBF800000, 32'h00000000});
    vecs.push_back('{"sub_half",  32'h3F800000, 32'hBF000000, 32'h3F000000});
    vecs.push_back('{"ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000});
    vecs.push_back('{"inf_minf",  32'h7F800000, 32'hFF800000, 32'h7FC00000});
    vecs.push_back('{"nz_nz",     32'h80000000, 32'h80000000, 32'h80000000});
    vecs.push_back('{"pz_nz",     32'h00000000, 32'h80000000, 32'h00000000});
    vecs.push_back('{"nan",       32'h7FC00001, 32'h3F800000, 32'h7FC00000});
    vecs.push_back('{"inf_one",   32'h3F800000, 32'hFF800000, 32'hFF800000});
    vecs.push_back('{"zero_x",    32'h00000000, 32'h40490FDB, 32'h40490FDB});
    vecs.push_back('{"denorm_x",  32'h00000001, 32'h3F800000, 32'h3F800000});
    vecs.push_back('{"far_tie",   32'h4B800000, 32'h3F800000, 32'h4B800000});
    vecs.push_back('{"far_exact", 32'h4B800000, 32'h40000000, 32'h4B800001});
    vecs.push_back('{"huge_diff", 32'h7F000000, 32'h3F800000, 32'h7F000000});
    vecs.push_back('{"uflow",     32'h00800000, 32'h80800001, 32'h80000000});
    vecs.push_back('{"neg_add",   32'hBF800000, 32'hBF800000, 32'hC0000000});
    vecs.push_back('{"mix_sign",  32'hBF800000, 32'h40000000, 32'h3F800000});

    // Consecutive calls change the pair every cycle with in_valid held high.
    foreach (vecs[i]) add_chk(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].exp);

    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.A        = 32'h3F800000;
    bus_if.B        = 32'h3F800000;
    @(posedge clk);
    #1;
    check("idle_hold", bus_if.out, 32'h3F800000);
    check("idle_valid", {31'd0, bus_if.out_valid}, 32'd0);

    add_chk("pre_rst", 32'h3F000000, 32'h3F000000, 32'h3F800000);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", bus_if.out, 32'h0);
    check("mid_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    add_chk("post_rst", 32'h3E800000, 32'h3F000000, 32'h3F400000);

    @(negedge clk);
    bus_if.in_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
